wb_retire_stage: RTL
====================

# wb_retire_stage

Parametrised writeback-stage unit for the five-stage MIPS pipeline. It owns the M/W pipeline register, decodes the instruction held in W, and drives the register-file write port. The write port is fed with sign/zero-extended load data, PC+8 link values or HI/LO reads. It adds stall/flush handling, single-shot retirement, misaligned-load suppression and a retired-instruction counter.

## Interface
Parameters:
- `CNT_W`, 32: width of retired-instruction counter.
- `ALIGN_CHECK`, 1: 1 = misaligned lh/lhu/lw suppress write and flag error; 0 = no check, low address bits ignored.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `valid_M` in 1: M stage holds a real instruction.
- `flush_M` in 1: squash the M instruction instead of capturing it.
- `stall_W` in 1: hold W register contents.
- `IR_M` in 32: instruction in M.
- `PC8_M` in 32: PC+8 of the M instruction.
- `ALU_M` in 32: ALU result / load address.
- `DM_M` in 32: raw data-memory word read.
- `HILO_M` in 32: HI or LO value already selected in M.
- `IR_W` out 32: instruction in W, for hazard logic.
- `GPR_we` out 1: register-file write enable.
- `GPR_wa` out 5: write address.
- `GPR_wd` out 32: write data.
- `retire_valid` out 1: one-cycle pulse per retired instruction.
- `retire_cnt` out CNT_W: retired-instruction count.
- `align_err` out 1: sticky misaligned-load flag.

## Operation
- **W register update (each edge):**
  - `reset`: IR_W=0, valid_W=0, data fields=0, retired=0.
  - `stall_W`: hold all fields; retired←1 if valid_W.
  - `flush_M` or !valid_M: capture bubble (IR=0, valid_W=0).
  - Otherwise: capture the M fields, valid_W=1, retired=0.
- **Decode classes:** R-cal, I-cal, shift, set, jal/jalr, mfhi/mflo, load (lb, lbu, lh, lhu, lw). IR=0 is a nop and never writes.
- **WRsel:**
  - 00 = rd: R-type, shift, slt/sltu, jalr, mf.
  - 01 = rt: I-cal, slti/sltiu, load.
  - 10 = 31: jal.
- **WDsel:**
  - 00 = ALU.
  - 01 = extended DM.
  - 10 = PC8.
  - 11 = HILO.
- **Load extension, EXTop:** lw 000, lbu 001, lb 010, lhu 011, lh 100.
  - Bytes are selected by ALU[1:0] (little-endian); halfwords by ALU[1].
  - lb/lh sign-extend; lbu/lhu zero-extend.
- **Write enable:** GPR_we = valid_W & !retired & class_writes & (GPR_wa≠0) & !misalign.
- **Misalign (ALIGN_CHECK=1):**
  - Condition: (lh|lhu)&ALU[0], or lw&(ALU[1:0]≠0).
  - On the retire cycle the write is suppressed and align_err sets.
  - align_err clears only on reset.
- **Retirement:** retire_valid = valid_W & !retired.
  - retire_cnt increments on that cycle and wraps modulo 2^CNT_W.
  - Suppressed writes (rd=0, misaligned) still retire.

## Timing
- Latency: M fields are registered into W on the edge after they are presented. GPR_we/wa/wd are combinational from the W register and committed by the GPR on the following edge.
- Stalled instruction: it writes and retires only in its first W cycle. Later stalled cycles show GPR_we=0 and retire_valid=0; GPR_wa/wd remain stable.
- Simultaneous stall_W and flush_M: stall wins, W unchanged, and the flushed M instruction is not captured.
- Reset mid-stall: W becomes a bubble, counter=0, align_err=0.
- All outputs reset low/zero, including IR_W=0.

## Structure
- Shared package `mips_pkg`:
  - op/funct constants and `RS/RT/RD` field ranges.
  - WRsel, WDsel and EXTop encodings.
- Sub-module `wb_decode`: purely combinational IR → {class_writes, WRsel, WDsel, EXTop, is_load_h, is_load_w}.
- Top-level: W register, retired flag, extender, muxes, counter, sticky flag.

## Test plan
- **lb sign-extension:** lb, rt=8, ALU_M=0x1003, DM_M=0x80FF_FFFF → one cycle later GPR_we=1, wa=8, wd=0xFFFF_FF80, retire_cnt=1.
- **lhu zero-extension:** lhu with ALU_M=0x2002, DM_M=0xBEEF_1234 → wd=0x0000_BEEF. The same lh with ALU_M=0x2001 → GPR_we=0, align_err=1 (stays 1), retire_valid pulses.
- **jal link:** jal with PC8_M=0x0040_0008 → wa=31, wd=0x0040_0008. jalr rd=0 → GPR_we=0, still retires.
- **Stall hold:** addu rd=5 then stall_W for 3 cycles → GPR_we high exactly 1 cycle, retire_cnt +1 only, IR_W held.
- **Flush/bubble:** flush_M=1 with valid_M=1 → IR_W=0, no write, no retire. stall_W+flush_M together → W unchanged.
- **Counter wrap and reset:** with CNT_W=4, 17 retiring instructions → retire_cnt=1. Reset asserted mid-stall → all outputs 0 next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared definitions for the five-stage MIPS pipeline: instruction field
//   ranges, opcode/funct constants, the writeback mux-select encodings and a
//   helper that extracts and extends a loaded byte/halfword from a memory word.
package mips_pkg;

  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  typedef enum logic [1:0] {
    WR_RD = 2'b00,
    WR_RT = 2'b01,
    WR_RA = 2'b10
  } wrsel_e;

  typedef enum logic [1:0] {
    WD_ALU  = 2'b00,
    WD_DM   = 2'b01,
    WD_PC8  = 2'b10,
    WD_HILO = 2'b11
  } wdsel_e;

  typedef enum logic [2:0] {
    EXT_LW  = 3'b000,
    EXT_LBU = 3'b001,
    EXT_LB  = 3'b010,
    EXT_LHU = 3'b011,
    EXT_LH  = 3'b100
  } extop_e;

  // Little-endian lane selection: the byte comes from addr[1:0], the
  // halfword from addr[1]; whole words pass through untouched.
  function automatic logic [31:0] extendLoad(input extop_e op,
                                             input logic [1:0] addr,
                                             input logic [31:0] word);
    logic [7:0]  byteVal;
    logic [15:0] halfVal;
    byteVal = word[{addr, 3'b000} +: 8];
    halfVal = addr[1] ? word[31:16] : word[15:0];
    case (op)
      EXT_LBU: extendLoad = {24'h000000, byteVal};
      EXT_LB:  extendLoad = {{24{byteVal[7]}}, byteVal};
      EXT_LHU: extendLoad = {16'h0000, halfVal};
      EXT_LH:  extendLoad = {{16{halfVal[15]}}, halfVal};
      default: extendLoad = word;
    endcase
  endfunction

endpackage

// File: rtl/wb_decode.sv
// wb_decode
//   Purely combinational decoder for the instruction held in W.
//   i_ir          : instruction word
//   o_classWrites : instruction belongs to a class that writes the GPR file
//   o_wrSel       : write-address source (rd / rt / 31)
//   o_wdSel       : write-data source (ALU / extended DM / PC8 / HILO)
//   o_extOp       : load extension mode
//   o_isLoadH     : lh or lhu (halfword alignment applies)
//   o_isLoadW     : lw (word alignment applies)
module wb_decode
  import mips_pkg::*;
(
  input  logic [31:0] i_ir,
  output logic        o_classWrites,
  output wrsel_e      o_wrSel,
  output wdsel_e      o_wdSel,
  output extop_e      o_extOp,
  output logic        o_isLoadH,
  output logic        o_isLoadW
);

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic       w_isNop;

  assign w_op    = i_ir[31:26];
  assign w_funct = i_ir[5:0];
  assign w_isNop = (i_ir == 32'h0000_0000);

  // Classify the instruction. Anything not recognised as a writer (stores,
  // branches, jr, mult/div, mthi/mtlo) falls through to the defaults and
  // never touches the register file. The all-zero word is a nop even though
  // it aliases sll $0,$0,0, so it is excluded up front.
  always_comb begin
    o_classWrites = 1'b0;
    o_wrSel       = WR_RD;
    o_wdSel       = WD_ALU;
    o_extOp       = EXT_LW;
    o_isLoadH     = 1'b0;
    o_isLoadW     = 1'b0;
    if (!w_isNop) begin
      case (w_op)
        OP_RTYPE: begin
          case (w_funct)
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
            FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV,
            FN_SRAV: o_classWrites = 1'b1;
            FN_JALR: begin
              o_classWrites = 1'b1;
              o_wdSel       = WD_PC8;
            end
            FN_MFHI, FN_MFLO: begin
              o_classWrites = 1'b1;
              o_wdSel       = WD_HILO;
            end
            default: o_classWrites = 1'b0;
          endcase
        end
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
        OP_LUI: begin
          o_classWrites = 1'b1;
          o_wrSel       = WR_RT;
        end
        OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
          o_classWrites = 1'b1;
          o_wrSel       = WR_RT;
          o_wdSel       = WD_DM;
          case (w_op)
            OP_LB:   o_extOp = EXT_LB;
            OP_LBU:  o_extOp = EXT_LBU;
            OP_LH:   o_extOp = EXT_LH;
            OP_LHU:  o_extOp = EXT_LHU;
            default: o_extOp = EXT_LW;
          endcase
          o_isLoadH = (w_op == OP_LH) || (w_op == OP_LHU);
          o_isLoadW = (w_op == OP_LW);
        end
        OP_JAL: begin
          o_classWrites = 1'b1;
          o_wrSel       = WR_RA;
          o_wdSel       = WD_PC8;
        end
        default: o_classWrites = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/wb_retire_stage.sv
// wb_retire_stage
//   Writeback stage: owns the M/W pipeline register, drives the GPR write
//   port, and tracks retirement.
//   clk, reset (sync, active-high)
//   valid_M, flush_M, stall_W            : pipeline control
//   IR_M, PC8_M, ALU_M, DM_M, HILO_M     : fields captured from M
//   IR_W                                 : W instruction for hazard logic
//   GPR_we, GPR_wa, GPR_wd               : register-file write port
//   retire_valid, retire_cnt             : retirement pulse and counter
//   align_err                            : sticky misaligned-load flag
module wb_retire_stage
  import mips_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_M,
  input  logic             flush_M,
  input  logic             stall_W,
  input  logic [31:0]      IR_M,
  input  logic [31:0]      PC8_M,
  input  logic [31:0]      ALU_M,
  input  logic [31:0]      DM_M,
  input  logic [31:0]      HILO_M,
  output logic [31:0]      IR_W,
  output logic             GPR_we,
  output logic [4:0]       GPR_wa,
  output logic [31:0]      GPR_wd,
  output logic             retire_valid,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             align_err
);

  logic [31:0]      r_irW;
  logic [31:0]      r_pc8W;
  logic [31:0]      r_aluW;
  logic [31:0]      r_dmW;
  logic [31:0]      r_hiloW;
  logic             r_validW;
  logic             r_retired;
  logic [CNT_W-1:0] r_retireCnt;
  logic             r_alignErr;

  logic   w_classWrites;
  wrsel_e w_wrSel;
  wdsel_e w_wdSel;
  extop_e w_extOp;
  logic   w_isLoadH;
  logic   w_isLoadW;
  logic   w_misalign;
  logic   w_retire;

  wb_decode u_decode (
    .i_ir          (r_irW),
    .o_classWrites (w_classWrites),
    .o_wrSel       (w_wrSel),
    .o_wdSel       (w_wdSel),
    .o_extOp       (w_extOp),
    .o_isLoadH     (w_isLoadH),
    .o_isLoadW     (w_isLoadW)
  );

  // M/W register. A stall freezes every field and marks a live instruction
  // as already retired, so it writes and counts only in its first W cycle.
  // Stall takes priority over flush: the squashed M instruction is simply
  // never captured. Bubbles are fully zeroed so the write port reads clean.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_irW     <= '0;
      r_pc8W    <= '0;
      r_aluW    <= '0;
      r_dmW     <= '0;
      r_hiloW   <= '0;
      r_validW  <= 1'b0;
      r_retired <= 1'b0;
    end else if (stall_W) begin
      r_retired <= r_retired | r_validW;
    end else if (flush_M || !valid_M) begin
      r_irW     <= '0;
      r_pc8W    <= '0;
      r_aluW    <= '0;
      r_dmW     <= '0;
      r_hiloW   <= '0;
      r_validW  <= 1'b0;
      r_retired <= 1'b0;
    end else begin
      r_irW     <= IR_M;
      r_pc8W    <= PC8_M;
      r_aluW    <= ALU_M;
      r_dmW     <= DM_M;
      r_hiloW   <= HILO_M;
      r_validW  <= 1'b1;
      r_retired <= 1'b0;
    end
  end

  assign w_misalign = (ALIGN_CHECK != 1'b0) &&
                      ((w_isLoadH && r_aluW[0]) ||
                       (w_isLoadW && (r_aluW[1:0] != 2'b00)));
  assign w_retire   = r_validW && !r_retired;

  // Write-port muxes, driven straight from the W register.
  always_comb begin
    GPR_wa = r_irW[RD_HI:RD_LO];
    case (w_wrSel)
      WR_RT:   GPR_wa = r_irW[RT_HI:RT_LO];
      WR_RA:   GPR_wa = 5'd31;
      default: GPR_wa = r_irW[RD_HI:RD_LO];
    endcase
    GPR_wd = r_aluW;
    case (w_wdSel)
      WD_DM:   GPR_wd = extendLoad(w_extOp, r_aluW[1:0], r_dmW);
      WD_PC8:  GPR_wd = r_pc8W;
      WD_HILO: GPR_wd = r_hiloW;
      default: GPR_wd = r_aluW;
    endcase
  end

  // Retirement bookkeeping. Suppressed writes (rd=0 or misaligned) still
  // count; the alignment flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_retireCnt <= '0;
      r_alignErr  <= 1'b0;
    end else begin
      if (w_retire) begin
        r_retireCnt <= r_retireCnt + CNT_W'(1);
      end
      if (w_retire && w_misalign) begin
        r_alignErr <= 1'b1;
      end
    end
  end

  assign IR_W         = r_irW;
  assign GPR_we       = w_retire && w_classWrites && (GPR_wa != 5'd0) && !w_misalign;
  assign retire_valid = w_retire;
  assign retire_cnt   = r_retireCnt;
  assign align_err    = r_alignErr;

endmodule
